// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle for the execute-stage ALU
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU, single-cycle logic ops, 1-bit-per-cycle shifts
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [SHAMT_W-1:0] count_q;
    logic               shift_left_q;

    logic [WIDTH-1:0]   alu_d;
    logic [WIDTH-1:0]   shreg_d;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;

    assign shamt    = bus.src_b[SHAMT_W-1:0];
    assign is_shift = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL);
    assign shreg_d  = shift_left_q ? (shreg_q << 1) : (shreg_q >> 1);

    // Reserved codes fall through to zero so the zero flag still tracks the result.
    always_comb begin
        alu_d = '0;
        case (bus.alu_control)
            OP_ADD:  alu_d = bus.src_a + bus.src_b;
            OP_SUB:  alu_d = bus.src_a - bus.src_b;
            OP_AND:  alu_d = bus.src_a & bus.src_b;
            OP_OR:   alu_d = bus.src_a | bus.src_b;
            OP_XOR:  alu_d = bus.src_a ^ bus.src_b;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_JAL:  alu_d = bus.src_a + WIDTH'(4);
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            result_q     <= '0;
            zero_q       <= 1'b0;
            shreg_q      <= '0;
            count_q      <= '0;
            shift_left_q <= 1'b0;
        end else if (flush) begin
            // Result registers keep their stale value; only the valid indication drops.
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_shift) begin
                            shreg_q      <= bus.src_a;
                            count_q      <= shamt;
                            shift_left_q <= (bus.alu_control == OP_SLL);
                            if (shamt == '0) begin
                                result_q <= bus.src_a;
                                zero_q   <= (bus.src_a == '0);
                                state_q  <= ST_DONE;
                            end else begin
                                state_q  <= ST_SHIFT;
                            end
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= shreg_d;
                    count_q <= count_q - SHAMT_W'(1);
                    if (count_q == SHAMT_W'(1)) begin
                        result_q <= shreg_d;
                        zero_q   <= (shreg_d == '0);
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
    logic clk;
    logic rst_n;
    logic flush;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return {31'd0, ($signed(a) < $signed(b))};
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return a + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t e;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.alu_control = ctl;
        bus.src_a       = a;
        bus.src_b       = b;
        if (track) begin
            e.res = model(ctl, a, b);
            e.lat = (ctl == 4'd6 || ctl == 4'd7) ? 1 + int'(b[4:0]) : 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.alu_control = 4'($urandom_range(0, 15));
        bus.src_a       = $urandom;
        bus.src_b       = $urandom;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) begin
            check_eq({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_lat"}, 32'(lat), 32'(e.lat));
            check_eq({tag, "_res"}, bus.result, e.res);
            check_eq({tag, "_zero"}, 32'(bus.zero), 32'(e.res == 32'd0));
            check_eq({tag, "_inrdy_busy"}, 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, "_ovld_off"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        issue(ctl, a, b, 1'b1);
        collect(tag);
        drain(tag);
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.alu_control = 4'd0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.out_ready   = 1'b0;
        #12;
        check_eq("rst_ovld", 32'(bus.out_valid), 32'd0);
        check_eq("rst_res", bus.result, 32'd0);
        check_eq("rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_inrdy", 32'(bus.in_ready), 32'd1);

        run("add", 4'd0, 32'h0000_0005, 32'h0000_0003);
        run("sub_zero", 4'd1, 32'h1234_5678, 32'h1234_5678);
        run("sub_wrap", 4'd1, 32'h0000_0000, 32'h0000_0001);
        run("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'h0000_0001);
        run("slt_swap", 4'd5, 32'h0000_0001, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            run("and", 4'd2, $urandom, $urandom);
            run("or", 4'd3, $urandom, $urandom);
            run("xor", 4'd4, $urandom, $urandom);
        end
        run("sll31", 4'd6, 32'h0000_0001, 32'h0000_001F);
        run("srl4", 4'd7, 32'h8000_0000, 32'h0000_0024);
        run("sll0", 4'd6, 32'hDEAD_BEEF, 32'h0000_0000);
        run("srl_rand", 4'd7, $urandom, $urandom);

        // Backpressure: result must hold and new requests must be ignored.
        issue(4'd8, 32'h0000_1000, 32'h0, 1'b1);
        collect("jal");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid    = 1'b1;
            bus.alu_control = 4'd0;
            bus.src_a       = 32'h1;
            bus.src_b       = 32'h1;
            @(negedge clk);
            check_eq("bp_res", bus.result, 32'h0000_1004);
            check_eq("bp_inrdy", 32'(bus.in_ready), 32'd0);
            check_eq("bp_ovld", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        drain("jal");

        // Flush in cycle N+3 of a 10-bit shift.
        issue(4'd7, 32'hF0F0_F0F0, 32'd10, 1'b0);
        @(negedge clk);
        check_eq("fl_ovld1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_eq("fl_ovld2", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("fl_inrdy", 32'(bus.in_ready), 32'd1);
        check_eq("fl_res_kept", bus.result, 32'h0000_1004);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("fl_ovld_never", 32'(bus.out_valid), 32'd0);
        end

        // in_valid coincident with flush is dropped.
        bus.in_valid    = 1'b1;
        bus.alu_control = 4'd0;
        flush           = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        check_eq("flv_inrdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_eq("flv_ovld", 32'(bus.out_valid), 32'd0);

        // Async reset in the middle of a shift.
        issue(4'd6, 32'h0000_0003, 32'd20, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ar_ovld", 32'(bus.out_valid), 32'd0);
        check_eq("ar_res", bus.result, 32'd0);
        check_eq("ar_inrdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run("reserved", 4'b1010, 32'h1357_9BDF, 32'h2468_ACE0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder, together with the two operands, and produces a registered result and a zero flag.
- Single-cycle ops (add/sub/and/or/xor/slt/jal) complete in 1 cycle.
- Shifts (sll/srl) run iteratively, 1 bit per cycle, to keep the shifter small.
- valid/ready handshakes on both sides; a synchronous flush input aborts in-flight work on redirect.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width = $clog2(WIDTH); shift amount is src_b[SHAMT_W-1:0].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of any accepted/in-flight op.
- in_valid  input  1  operands and ALUControl valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- alu_control  input  4  op code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 jal; 1001-1111 reserved.
- src_a  input  WIDTH  operand A (PC for jal).
- src_b  input  WIDTH  operand B / shift amount.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; out_valid=0, result=0, zero=0.
  - in_ready=1 once rst_n=1.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: a transfer occurs when in_valid && in_ready && !flush on a rising edge (cycle N).
- IDLE, non-shift op accepted at N:
  - result is computed and registered; state -> DONE; out_valid=1 in cycle N+1.
  - add: a+b mod 2^WIDTH.
  - sub: a-b mod 2^WIDTH.
  - and / or / xor: bitwise.
  - slt: signed compare, result = {0..0, (a<b)}.
  - jal: a+4 mod 2^WIDTH.
  - reserved codes: result=0.
- IDLE, shift op accepted at N:
  - Load shift register with src_a and count = src_b[SHAMT_W-1:0] (k).
  - If k==0: result=src_a, state -> DONE.
  - Else: state -> SHIFT.
  - Each SHIFT cycle shifts 1 bit (sll: left, zero fill; srl: right, zero fill) and decrements count. When count==1 the final shift is written to result and state -> DONE.
  - out_valid is asserted in cycle N+1+k; max latency 1+(WIDTH-1) = 32 cycles.
  - Upper bits src_b[WIDTH-1:SHAMT_W] are ignored.
- zero is registered together with result and is always consistent with it: zero=1 iff result==0, including reserved codes.
- DONE:
  - result and zero are held stable while out_valid && !out_ready.
  - On out_ready: state -> IDLE, out_valid=0 next cycle.
  - No input is accepted in the same cycle as out_ready; back-to-back throughput is 1 op per 2 cycles minimum.
- flush (synchronous, highest priority after reset):
  - In any state, the next state is IDLE and out_valid=0.
  - result and zero keep their last value, but that value is not valid.
  - An in_valid coincident with flush is not accepted.
- Async reset mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded.
- in_valid while not IDLE is ignored; the upstream must hold its inputs until in_ready.
- Inputs are sampled only on the accept edge; changes afterwards do not affect an in-flight op.

Test Plan:
- Reset then add: a=0x00000005, b=0x00000003, ctl=0000 accepted at N -> out_valid at N+1, result=0x00000008, zero=0; out_ready=1 -> in_ready=1 at N+2.
- Sub to zero, and wrap: a=b=0x12345678, ctl=0001 -> result=0, zero=1. Then a=0, b=1 -> result=0xFFFFFFFF, zero=0.
- slt signed: a=0xFFFFFFFF, b=0x00000001, ctl=0101 -> result=1. Swapped operands -> result=0, zero=1.
- Shifts:
  - sll a=0x00000001, b=0x0000001F -> out_valid exactly at N+32, result=0x80000000.
  - srl a=0x80000000, b=0x00000024 (amount 4) -> result at N+5 = 0x08000000.
  - sll b=0 -> result=a at N+1.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles after a jal (a=0x00001000) -> result stays 0x00001004, in_ready=0 throughout.
  - Assert flush at cycle N+3 of a 10-bit shift -> out_valid never rises; in_ready=1 at N+4.
- Async reset mid-SHIFT: drop rst_n during a shift -> out_valid=0 and result=0 immediately (without waiting for a clock edge). After release, a reserved ctl=1010 op -> result=0, zero=1.
